if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Decoupling queue between the fetch stage and decode.
- Captures each fetched packet (pc, pc_nxt, instr) and presents packets in order to decode through a valid/ready handshake.
- Absorbs decode stalls without losing fetched words; discards all in-flight packets on a control-flow redirect (flush).
- PC values are word indices, consistent with the fetch stage (pc_nxt = pc + 1).

Parameters:
- DEPTH, 2, number of packet entries; power of two, >= 2.
- NOP_INSTR, 32'h0000_0013, instruction driven on out_instr whenever out_valid = 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all queued packets and any same-cycle push.
- in_valid  input  1  fetch presents a packet.
- in_pc  input  32  PC of fetched instruction.
- in_pc_nxt  input  32  sequential next PC of that instruction.
- in_instr  input  32  fetched instruction word.
- in_ready  output  1  queue can accept a packet this cycle.
- out_valid  output  1  head packet valid for decode.
- out_pc  output  32  head packet PC.
- out_pc_nxt  output  32  head packet next PC.
- out_instr  output  32  head packet instruction, or NOP_INSTR when empty.
- out_ready  input  1  decode consumes the head packet this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - count = 0, read/write pointers = 0.
  - out_valid = 0, out_pc = 0, out_pc_nxt = 0, out_instr = NOP_INSTR, in_ready = 1.
  - Reset has priority over flush, push and pop.
  - Reset asserted mid-operation drops all entries identically.
- Handshakes:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
- Readiness and validity:
  - in_ready = (count < DEPTH), a function of registered state only; no combinational path from out_ready to in_ready.
  - out_valid = (count != 0), registered-state only.
  - out_pc, out_pc_nxt and out_instr come from the head entry when out_valid = 1.
  - When out_valid = 0: out_pc = 0, out_pc_nxt = 0, out_instr = NOP_INSTR.
- Latency: no fall-through. A packet pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1 at the earliest.
- Occupancy update:
  - push only: count + 1.
  - pop only: count - 1.
  - push & pop: count unchanged; head advances and tail writes.
- Full (count = DEPTH):
  - in_ready = 0; in_valid ignored even if out_ready = 1 that cycle.
  - in_ready rises in the cycle after the pop.
- Empty: out_ready is ignored; count never underflows.
- Pointers:
  - Width $clog2(DEPTH); wrap naturally modulo DEPTH.
  - Ordering is strictly FIFO across wrap-around.
- Flush:
  - Next cycle: count = 0, out_valid = 0, pointers reset to 0.
  - A same-cycle push is dropped; a same-cycle pop is not counted.
  - The packet pushed in the cycle after flush (the redirect target) is accepted normally.
- Flush and in_valid both high: the incoming packet is never stored.
- Storage contents are not reset; only pointers and count are. Stale data is never visible because out_* are masked by out_valid.
- Explicit state: the logic is a counter/pointer machine, not an encoded FSM. It has three derived states:
  - EMPTY (count = 0)
  - PARTIAL (0 < count < DEPTH)
  - FULL (count = DEPTH)
- State transitions follow only the count update rules above.

Decomposition:
- Shared pipeline package/include (rv32_pipe_pkg) holds:
  - NOP_INSTR constant (32'h0000_0013).
  - Fetch-packet field widths: XLEN = 32, packet = {pc, pc_nxt, instr} = 96 bits.
  - The pack/unpack ordering.
- One sub-module is natural: if_id_queue_mem, a DEPTH x 96-bit register array with one synchronous write port and one combinational read port.
- Pointer/count control stays in if_id_queue.

Test Plan:
- Reset with rst = 1 for 2 cycles, then 0 -> count = 0, out_valid = 0, out_instr = 32'h0000_0013, in_ready = 1.
- Push (pc = 0, nxt = 1, instr = 32'h0015_8593) with out_ready = 0, then push (pc = 1, nxt = 2, same instr) -> count = 2, in_ready = 0, and the third in_valid is ignored. Then raise out_ready -> packets exit in order pc = 0 then pc = 1, with in_ready = 1 in the cycle after the first pop.
- Continuous streaming, in_valid = out_ready = 1 for 10 cycles with pc 0..9 -> out_pc sequence 0..9 one cycle delayed, count holds 1, pointers wrap without loss.
- With count = 2, assert flush together with in_valid (pc = 5) -> next cycle count = 0, out_valid = 0, pc = 5 never appears. Push pc = 8 in the following cycle -> it appears as out_pc = 8.
- Assert rst while count = 2 and out_ready = 0 -> next cycle all outputs at reset values. A subsequent push of pc = 3 is the first packet out.
- Full queue with simultaneous out_ready = 1 and in_valid = 1 -> pop occurs, push rejected, count = DEPTH - 1.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg: shared fetch/decode packet definitions for the pipeline.
package rv32_pipe_pkg;
   localparam int XLEN = 32;
   localparam int PKT_W = 3 * XLEN;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_nxt;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;
   typedef enum logic [1:0] {Q_EMPTY, Q_PARTIAL, Q_FULL} q_state_e;
   function automatic fetch_pkt_t pack_pkt(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] pc_nxt,
                                           input logic [XLEN-1:0] instr);
      return '{pc: pc, pc_nxt: pc_nxt, instr: instr};
   endfunction
endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: packet storage, one synchronous write port and one combinational read port.
module if_id_queue_mem
   import rv32_pipe_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  fetch_pkt_t       i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output fetch_pkt_t       o_rdata
);
   fetch_pkt_t r_mem [DEPTH];
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order fetch->decode packet queue with stall absorption and flush on redirect.
// Outputs depend on registered state only, so there is no fall-through and no out_ready->in_ready path.
module if_id_queue
   import rv32_pipe_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter logic [31:0] NOP_INSTR = rv32_pipe_pkg::NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_pc_nxt,
   input  logic [31:0]              in_instr,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_pc_nxt,
   output logic [31:0]              out_instr,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push, w_pop;
   q_state_e      w_state;
   fetch_pkt_t    w_head;
   always_comb begin
      w_state = r_count == '0 ? Q_EMPTY : (r_count == FULL_CNT ? Q_FULL : Q_PARTIAL);
      in_ready = w_state != Q_FULL;
      out_valid = w_state != Q_EMPTY;
      w_push = in_valid & in_ready & ~flush;
      w_pop = out_valid & out_ready & ~flush;
   end
   // Flush shares the reset path: pointers and count return to zero, storage is left as is.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count <= '0;
      end else begin
         r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
         r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
         r_count <= (w_push && !w_pop) ? r_count + (AW+1)'(1) :
                    (w_pop && !w_push) ? r_count - (AW+1)'(1) : r_count;
      end
   end
   if_id_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (pack_pkt(in_pc, in_pc_nxt, in_instr)),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_head)
   );
   always_comb begin
      out_pc = out_valid ? w_head.pc : '0;
      out_pc_nxt = out_valid ? w_head.pc_nxt : '0;
      out_instr = out_valid ? w_head.instr : NOP_INSTR;
   end
   assign count = r_count;
endmodule
